// File: rtl/fifo_pkg.sv
// Shared defaults, read-mode enum and width helpers for the programmable sync FIFO.
// Pure declarations; no logic, no latency, no flow control.
// Imported by fifo_sync_prog and fifo_mem.
package fifo_pkg;

   localparam int DEF_FIFO_WIDTH = 16;
   localparam int DEF_FIFO_DEPTH = 8;

   typedef enum logic {
      STD  = 1'b0,
      FWFT = 1'b1
   } fifo_mode_e;

   // A two-entry FIFO still needs one address bit.
   function automatic int calc_addr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int calc_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register array with one synchronous write port and one asynchronous read port.
// Latency: write lands on the clock edge; read data is combinational from raddr.
// No flow control; the caller gates we.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH  = DEF_FIFO_WIDTH,
   parameter int DEPTH  = DEF_FIFO_DEPTH,
   parameter int ADDR_W = calc_addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with occupancy count, live almost-full/empty thresholds, flush and STD/FWFT read.
// Latency: STD read data 1 cycle after rd_en; FWFT head visible the cycle after it is written.
// Backpressure: writes to a full FIFO are dropped (overflow) unless a read frees a slot that cycle.
module fifo_sync_prog
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int FWFT       = 0,
   localparam int ADDR_W    = calc_addr_w(FIFO_DEPTH),
   localparam int CNT_W     = calc_cnt_w(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic                  flush,
   input  logic [CNT_W-1:0]      af_thresh,
   input  logic [CNT_W-1:0]      ae_thresh,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [CNT_W-1:0]      count
);

   localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;

   logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      cnt;
   logic [FIFO_WIDTH-1:0] mem_rdata;
   logic                  wr_acc, rd_acc;
   logic                  wr_ack_q, ovf_q, udf_q;

   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      return (p == ADDR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full   = (cnt == CNT_W'(FIFO_DEPTH));
   assign empty  = (cnt == '0);
   assign rd_acc = rd_en & ~empty;
   // A read in the same cycle frees the slot, so a full FIFO still takes the write.
   assign wr_acc = wr_en & (~full | rd_acc);

   // cnt never exceeds FIFO_DEPTH, so threshold 0 / >DEPTH cases fall out of the compares.
   assign almostfull  = (cnt >= af_thresh);
   assign almostempty = (cnt <= ae_thresh);
   assign count       = cnt;
   assign wr_ack      = wr_ack_q;
   assign overflow    = ovf_q;
   assign underflow   = udf_q;

   fifo_mem #(
      .WIDTH  (FIFO_WIDTH),
      .DEPTH  (FIFO_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc & rst_n & ~flush),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         wr_ack_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         wr_ack_q <= wr_acc;
         ovf_q    <= wr_en & ~wr_acc;
         udf_q    <= rd_en & ~rd_acc;
      end
   end

   if (MODE == fifo_pkg::FWFT) begin : g_fwft
      assign data_out = empty ? '0 : mem_rdata;
      assign rd_valid = ~empty;
   end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout_q;
      logic                  vld_q;

      // Flush leaves the last read word on data_out.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
         end else if (flush) begin
            vld_q  <= 1'b0;
         end else begin
            vld_q <= rd_acc;
            if (rd_acc) dout_q <= mem_rdata;
         end
      end

      assign data_out = dout_q;
      assign rd_valid = vld_q;
   end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench: three instances (STD 16x8, STD 16x5, FWFT 16x8) share one stimulus bus;
// each task checks the instance its scenario targets.
module tb_fifo_sync_prog;

   logic        clk, rst_n, wr_en, rd_en, flush;
   logic [15:0] data_in;
   logic [3:0]  af_thresh, ae_thresh;

   logic [15:0] a_dout, b_dout, c_dout;
   logic        a_vld, a_ack, a_ovf, a_udf, a_full, a_empty, a_af, a_ae;
   logic        b_vld, b_ack, b_ovf, b_udf, b_full, b_empty, b_af, b_ae;
   logic        c_vld, c_ack, c_ovf, c_udf, c_full, c_empty, c_af, c_ae;
   logic [3:0]  a_cnt, c_cnt;
   logic [2:0]  b_cnt;

   int n_cmp = 0;
   int n_err = 0;

   fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .data_out(a_dout), .rd_valid(a_vld),
      .wr_ack(a_ack), .overflow(a_ovf), .underflow(a_udf), .full(a_full), .empty(a_empty),
      .almostfull(a_af), .almostempty(a_ae), .count(a_cnt));

   fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u_d5 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .af_thresh(af_thresh[2:0]), .ae_thresh(ae_thresh[2:0]), .data_out(b_dout), .rd_valid(b_vld),
      .wr_ack(b_ack), .overflow(b_ovf), .underflow(b_udf), .full(b_full), .empty(b_empty),
      .almostfull(b_af), .almostempty(b_ae), .count(b_cnt));

   fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .data_out(c_dout), .rd_valid(c_vld),
      .wr_ack(c_ack), .overflow(c_ovf), .underflow(c_udf), .full(c_full), .empty(c_empty),
      .almostfull(c_af), .almostempty(c_ae), .count(c_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (a_cnt !== 4'd0)   begin n_err++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
      n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", a_empty); end
      n_cmp++; if (a_full !== 1'b0)  begin n_err++; $display("FAIL reset_full got %b exp 0", a_full); end
      n_cmp++; if (a_dout !== 16'h0) begin n_err++; $display("FAIL reset_dout got %h exp 0000", a_dout); end
      n_cmp++; if ({a_vld, a_ack, a_ovf, a_udf} !== 4'b0)
         begin n_err++; $display("FAIL reset_strobes got %b exp 0000", {a_vld, a_ack, a_ovf, a_udf}); end
      n_cmp++; if ({c_vld, c_dout} !== 17'h0)
         begin n_err++; $display("FAIL reset_fwft got vld=%b dout=%h exp 0/0000", c_vld, c_dout); end
   endtask

   task automatic test_fill_drain();
      af_thresh = 4'd6; ae_thresh = 4'd2;
      for (int i = 1; i <= 8; i++) begin
         data_in = 16'(i); wr_en = 1'b1;
         tick();
         n_cmp++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL fill_ack[%0d] got %b exp 1", i, a_ack); end
         n_cmp++; if (a_cnt !== 4'(i)) begin n_err++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, a_cnt, i); end
         n_cmp++; if ({a_af, a_ae, a_full} !== {i >= 6, i <= 2, i == 8})
            begin n_err++; $display("FAIL fill_flags[%0d] got af/ae/full=%b exp %b", i, {a_af, a_ae, a_full}, {i >= 6, i <= 2, i == 8}); end
      end
      idle();
      for (int i = 1; i <= 8; i++) begin
         rd_en = 1'b1;
         tick();
         n_cmp++; if ({a_vld, a_dout} !== {1'b1, 16'(i)})
            begin n_err++; $display("FAIL drain[%0d] got vld=%b dout=%h exp 1/%h", i, a_vld, a_dout, 16'(i)); end
         n_cmp++; if (a_cnt !== 4'(8 - i)) begin n_err++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, a_cnt, 8 - i); end
      end
      idle();
      tick();
      n_cmp++; if ({a_empty, a_vld, a_dout} !== {1'b1, 1'b0, 16'h0008})
         begin n_err++; $display("FAIL drain_end got empty=%b vld=%b dout=%h exp 1/0/0008", a_empty, a_vld, a_dout); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 8; i++) begin
         data_in = 16'h0010 + 16'(i); wr_en = 1'b1;
         tick();
      end
      data_in = 16'hBBBB;
      tick();
      n_cmp++; if ({a_ovf, a_ack, a_cnt} !== {1'b1, 1'b0, 4'd8})
         begin n_err++; $display("FAIL ovf got ovf=%b ack=%b cnt=%0d exp 1/0/8", a_ovf, a_ack, a_cnt); end
      // Threshold edge cases while full, sampled combinationally.
      wr_en = 1'b0; af_thresh = 4'd9; ae_thresh = 4'd8;
      #1;
      n_cmp++; if ({a_af, a_ae} !== 2'b01) begin n_err++; $display("FAIL thr_edge got af/ae=%b exp 01", {a_af, a_ae}); end
      af_thresh = 4'd0; ae_thresh = 4'd7;
      #1;
      n_cmp++; if ({a_af, a_ae} !== 2'b10) begin n_err++; $display("FAIL thr_zero got af/ae=%b exp 10", {a_af, a_ae}); end
      af_thresh = 4'd6; ae_thresh = 4'd2;
      data_in = 16'hAAAA; wr_en = 1'b1; rd_en = 1'b1;
      tick();
      n_cmp++; if ({a_ack, a_ovf, a_cnt, a_dout} !== {1'b1, 1'b0, 4'd8, 16'h0011})
         begin n_err++; $display("FAIL bypass got ack=%b ovf=%b cnt=%0d dout=%h exp 1/0/8/0011", a_ack, a_ovf, a_cnt, a_dout); end
      idle();
      for (int i = 2; i <= 9; i++) begin
         logic [15:0] exp;
         exp = (i == 9) ? 16'hAAAA : 16'h0010 + 16'(i);
         rd_en = 1'b1;
         tick();
         n_cmp++; if (a_dout !== exp) begin n_err++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, a_dout, exp); end
      end
      idle();
      tick();
   endtask

   task automatic test_underflow();
      rd_en = 1'b1;
      tick();
      n_cmp++; if ({a_udf, a_vld, a_cnt, a_dout} !== {1'b1, 1'b0, 4'd0, 16'hAAAA})
         begin n_err++; $display("FAIL udf got udf=%b vld=%b cnt=%0d dout=%h exp 1/0/0/aaaa", a_udf, a_vld, a_cnt, a_dout); end
      wr_en = 1'b1; data_in = 16'h5555;
      tick();
      n_cmp++; if ({a_cnt, a_udf, a_ack} !== {4'd1, 1'b1, 1'b1})
         begin n_err++; $display("FAIL empty_wr_rd got cnt=%0d udf=%b ack=%b exp 1/1/1", a_cnt, a_udf, a_ack); end
      wr_en = 1'b0;
      tick();
      n_cmp++; if ({a_dout, a_udf, a_vld} !== {16'h5555, 1'b0, 1'b1})
         begin n_err++; $display("FAIL udf_read got dout=%h udf=%b vld=%b exp 5555/0/1", a_dout, a_udf, a_vld); end
      idle();
   endtask

   task automatic test_flush_wrap();
      do_reset();
      for (int i = 0; i < 3; i++) begin data_in = 16'h0021 + 16'(i); wr_en = 1'b1; tick(); end
      wr_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd_en = 1'b1;
         tick();
         n_cmp++; if (b_dout !== 16'h0021 + 16'(i)) begin n_err++; $display("FAIL d5_read[%0d] got %h exp %h", i, b_dout, 16'h0021 + 16'(i)); end
      end
      rd_en = 1'b0;
      for (int i = 0; i < 5; i++) begin data_in = 16'h0031 + 16'(i); wr_en = 1'b1; tick(); end
      // af_thresh[2:0]=6 exceeds depth 5, so almostfull stays low even when full.
      n_cmp++; if ({b_cnt, b_full, b_af} !== {3'd5, 1'b1, 1'b0})
         begin n_err++; $display("FAIL d5_full got cnt=%0d full=%b af=%b exp 5/1/0", b_cnt, b_full, b_af); end
      rd_en = 1'b1;
      tick();
      n_cmp++; if (b_dout !== 16'h0031) begin n_err++; $display("FAIL d5_wrap_head got %h exp 0031", b_dout); end
      rd_en = 1'b0; wr_en = 1'b1; flush = 1'b1; data_in = 16'hDEAD;
      tick();
      n_cmp++; if ({b_cnt, b_empty, b_ack, b_ovf, b_vld} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0})
         begin n_err++; $display("FAIL flush got cnt=%0d empty=%b ack=%b ovf=%b vld=%b exp 0/1/0/0/0", b_cnt, b_empty, b_ack, b_ovf, b_vld); end
      n_cmp++; if (b_dout !== 16'h0031) begin n_err++; $display("FAIL flush_hold got %h exp 0031", b_dout); end
      flush = 1'b0; data_in = 16'h7777;
      tick();
      n_cmp++; if ({b_ack, b_cnt} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL post_flush_wr got ack=%b cnt=%0d exp 1/1", b_ack, b_cnt); end
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      n_cmp++; if (b_dout !== 16'h7777) begin n_err++; $display("FAIL post_flush_rd got %h exp 7777", b_dout); end
      idle();
   endtask

   task automatic test_fwft();
      do_reset();
      data_in = 16'h1234; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      n_cmp++; if ({c_vld, c_dout} !== {1'b1, 16'h1234}) begin n_err++; $display("FAIL fwft_show got vld=%b dout=%h exp 1/1234", c_vld, c_dout); end
      tick();
      n_cmp++; if ({c_vld, c_dout} !== {1'b1, 16'h1234}) begin n_err++; $display("FAIL fwft_hold got vld=%b dout=%h exp 1/1234", c_vld, c_dout); end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_cmp++; if ({c_empty, c_vld, c_dout} !== {1'b1, 1'b0, 16'h0})
         begin n_err++; $display("FAIL fwft_pop got empty=%b vld=%b dout=%h exp 1/0/0000", c_empty, c_vld, c_dout); end
      wr_en = 1'b1; data_in = 16'h00A1; tick();
      data_in = 16'h00A2; tick();
      wr_en = 1'b0; rd_en = 1'b1;
      n_cmp++; if (c_dout !== 16'h00A1) begin n_err++; $display("FAIL fwft_head got %h exp 00a1", c_dout); end
      tick();
      rd_en = 1'b0;
      n_cmp++; if ({c_dout, c_cnt} !== {16'h00A2, 4'd1}) begin n_err++; $display("FAIL fwft_next got dout=%h cnt=%0d exp 00a2/1", c_dout, c_cnt); end
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 1; i <= 5; i++) begin data_in = 16'h0040 + 16'(i); wr_en = 1'b1; tick(); end
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      n_cmp++; if ({a_cnt, a_dout} !== {4'd4, 16'h0041}) begin n_err++; $display("FAIL mid_pre got cnt=%0d dout=%h exp 4/0041", a_cnt, a_dout); end
      wr_en = 1'b1; rd_en = 1'b1; rst_n = 1'b0; data_in = 16'hEEEE;
      tick();
      rst_n = 1'b1; idle();
      n_cmp++; if ({a_cnt, a_empty, a_dout} !== {4'd0, 1'b1, 16'h0})
         begin n_err++; $display("FAIL mid_rst got cnt=%0d empty=%b dout=%h exp 0/1/0000", a_cnt, a_empty, a_dout); end
      n_cmp++; if ({a_vld, a_ack, a_ovf, a_udf} !== 4'b0)
         begin n_err++; $display("FAIL mid_rst_strobes got %b exp 0000", {a_vld, a_ack, a_ovf, a_udf}); end
      data_in = 16'h0099; wr_en = 1'b1;
      tick();
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_cmp++; if ({a_dout, a_cnt, a_vld} !== {16'h0099, 4'd0, 1'b1})
         begin n_err++; $display("FAIL mid_new got dout=%h cnt=%0d vld=%b exp 0099/0/1", a_dout, a_cnt, a_vld); end
   endtask

   initial begin
      rst_n = 1'b1; data_in = '0; af_thresh = 4'd6; ae_thresh = 4'd2;
      idle();
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_flush_wrap();
      test_fwft();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
